// File: rtl/uart_rx_fifo_if.sv
// Byte/handshake bundle between the UART receiver + host side and the receive FIFO.
// master: receiver/host side driving strobes; slave: the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int unsigned AW = 4
);
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tick_8x;
  logic        rd_en;
  logic        clr_ovr;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic [AW:0] level;
  logic        overrun;
  logic        timeout;

  modport master (
    output rx_data, rx_done, tick_8x, rd_en, clr_ovr,
    input  rd_data, empty, full, almost_full, level, overrun, timeout
  );

  modport slave (
    input  rx_data, rx_done, tick_8x, rd_en, clr_ovr,
    output rd_data, empty, full, almost_full, level, overrun, timeout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with level/overrun flags.
// Define UART_RX_FIFO_TIMEOUT_EN to build the character-timeout counter; otherwise timeout is 0.
module uart_rx_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AW            = 4,
  parameter int unsigned AF_LVL        = 12,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_nxt;
  logic          empty_q;
  logic          full_q;
  logic          af_q;
  logic          ovr_q;
  logic          push;
  logic          pop;
  logic          drop;

  // Full with a concurrent pop still accepts the byte: the pop frees the slot.
  always_comb begin
    push      = bus.rx_done && (!full_q || bus.rd_en);
    pop       = bus.rd_en && !empty_q;
    drop      = bus.rx_done && full_q && !bus.rd_en;
    level_nxt = level_q;
    if (push && !pop) begin
      level_nxt = level_q + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level_q - LW'(1);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= bus.rx_data;
    end
  end

  // Pointers, level and flags; flags are registered from the next level so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= (AF_LVL == 0);
      ovr_q   <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      level_q <= level_nxt;
      empty_q <= (level_nxt == '0);
      full_q  <= (level_nxt == LW'(DEPTH));
      af_q    <= (level_nxt >= LW'(AF_LVL));
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data     = mem[rp];
  assign bus.level       = level_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.overrun     = ovr_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_TICKS < 512) ? 9 : $clog2(TIMEOUT_TICKS + 1);

  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_nxt;
  logic          to_q;

  // Idle-time counter saturating at the threshold; any FIFO activity or emptiness restarts it.
  always_comb begin
    to_cnt_nxt = to_cnt;
    if (push || pop || empty_q) begin
      to_cnt_nxt = '0;
    end else if (bus.tick_8x && (to_cnt != TW'(TIMEOUT_TICKS))) begin
      to_cnt_nxt = to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      to_q   <= (to_cnt_nxt == TW'(TIMEOUT_TICKS)) && (level_nxt != '0);
    end
  end

  assign bus.timeout = to_q;
`else
  wire unused_tick = bus.tick_8x;

  assign bus.timeout = 1'b0;
`endif

endmodule
